ram8: RTL and testbench



---
 rtl/ram8.sv | 98 +++++++++
 tb/tb_ram8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ram8.sv
// ram8: 8 x 16-bit Hack RAM leaf.
// dmux tree steers load to one register; an 8-way mux drives out.
module dmux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = in & ~sel;
  assign b = in & sel;
endmodule

module dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic [3:0] out
);
  logic lo;
  logic hi;

  dmux u_top (
    .in (in),
    .sel(sel[1]),
    .a  (lo),
    .b  (hi)
  );

  dmux u_lo (
    .in (lo),
    .sel(sel[0]),
    .a  (out[0]),
    .b  (out[1])
  );

  dmux u_hi (
    .in (hi),
    .sel(sel[0]),
    .a  (out[2]),
    .b  (out[3])
  );
endmodule

module ram8 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] out
);
  logic [1:0]  half;
  logic [7:0]  en;
  logic [15:0] r [8];

  dmux u_half (
    .in (load),
    .sel(address[2]),
    .a  (half[0]),
    .b  (half[1])
  );

  dmux4way u_lo (
    .in (half[0]),
    .sel(address[1:0]),
    .out(en[3:0])
  );

  dmux4way u_hi (
    .in (half[1]),
    .sel(address[1:0]),
    .out(en[7:4])
  );

  // Reset wins over any write enable in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset)
        r[i] <= '0;
      else if (en[i])
        r[i] <= in;
    end
  end

  always_comb begin
    out = '0;
    unique case (address)
      3'd0: out = r[0];
      3'd1: out = r[1];
      3'd2: out = r[2];
      3'd3: out = r[3];
      3'd4: out = r[4];
      3'd5: out = r[5];
      3'd6: out = r[6];
      3'd7: out = r[7];
      default: out = '0;
    endcase
  end
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: vector table + scoreboard bench for ram8.
// Random phase compares against an 8-entry reference model.
module tb_ram8;
  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  always #5 clk = ~clk;

  ram8 dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  typedef struct {
    bit          chk;
    logic        rst;
    logic        ld;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [15:0] mdl [8];
  int          tests = 0;
  int          fails = 0;

  task automatic add(input bit chk, input logic rst, input logic ld,
                     input logic [2:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input string name);
    vec_t v;
    v.chk  = chk;
    v.rst  = rst;
    v.ld   = ld;
    v.a    = a;
    v.d    = d;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endtask

  // exp is the value out must show during the cycle, before the edge.
  task automatic step(input vec_t v);
    sb_t e;
    @(negedge clk);
    reset   = v.rst;
    load    = v.ld;
    address = v.a;
    in      = v.d;
    if (v.chk) begin
      e.name = v.name;
      e.exp  = v.exp;
      sb.push_back(e);
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (out !== e.exp) begin
        fails++;
        $display("FAIL %s addr=%0d: out=%h expected %h",
                 e.name, address, out, e.exp);
      end
    end
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = '0;
    end else if (v.ld) begin
      mdl[v.a] = v.d;
    end
  endtask

  initial begin
    vec_t v;
    reset   = 1'b0;
    load    = 1'b0;
    address = '0;
    in      = '0;

    add(1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 16'h0000, "rst");
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b0, 3'(k), 16'h0000, 16'h0000, "reset_clear");

    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b1, 3'(k), 16'(16'h1111 * (k + 1)),
          16'h0000, "write_old");
    for (int k = 7; k >= 0; k--)
      add(1'b1, 1'b0, 1'b0, 3'(k), 16'h0000,
          16'(16'h1111 * (k + 1)), "readback");

    add(1'b1, 1'b0, 1'b1, 3'd5, 16'hA5A5, 16'h6666, "preload5");
    add(1'b1, 1'b0, 1'b1, 3'd5, 16'h5A5A, 16'hA5A5, "rdw_before");
    add(1'b1, 1'b0, 1'b0, 3'd5, 16'h0000, 16'h5A5A, "rdw_after");
    add(1'b1, 1'b0, 1'b0, 3'd4, 16'h0000, 16'h5555, "rdw_nbr4");
    add(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000, 16'h7777, "rdw_nbr6");

    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b1, 3'(k), 16'h0F0F,
          (k == 5) ? 16'h5A5A : 16'(16'h1111 * (k + 1)), "fill_old");
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b0, 3'((k * 3) % 8), 16'hDEAD,
          16'h0F0F, "isolation");

    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b1, 3'(k), 16'(16'hC000 + k),
          16'h0F0F, "fill2_old");
    add(1'b1, 1'b1, 1'b1, 3'd3, 16'h1234, 16'hC003, "rst_prio_pre");
    for (int k = 0; k < 8; k++)
      add(1'b1, 1'b0, 1'b0, 3'(k), 16'h0000, 16'h0000, "rst_prio");
    add(1'b1, 1'b0, 1'b1, 3'd3, 16'h4321, 16'h0000, "rewrite_old");
    add(1'b1, 1'b0, 1'b0, 3'd3, 16'h0000, 16'h4321, "rewrite");
    add(1'b1, 1'b0, 1'b1, 3'd1, 16'hAAAA, 16'h0000, "b2b_a");
    add(1'b1, 1'b0, 1'b1, 3'd1, 16'hBBBB, 16'hAAAA, "b2b_b");
    add(1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 16'hBBBB, "b2b_last");

    foreach (vecs[i]) step(vecs[i]);

    for (int n = 0; n < 2000; n++) begin
      v.chk  = 1'b1;
      v.rst  = ($urandom_range(0, 99) == 0);
      v.ld   = 1'($urandom_range(0, 1));
      v.a    = 3'($urandom_range(0, 7));
      v.d    = 16'($urandom);
      v.exp  = mdl[v.a];
      v.name = "random";
      step(v);
    end

    for (int k = 0; k < 8; k++) begin
      v.chk  = 1'b1;
      v.rst  = 1'b0;
      v.ld   = 1'b0;
      v.a    = 3'(k);
      v.d    = 16'hDEAD;
      v.exp  = mdl[k];
      v.name = "final_sweep";
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
